// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared defaults, id-width helper and id type for the two-port SRAM arbiter
package sram_arb_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_CNT_W  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    typedef logic [clog2(DEF_N_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_find_first.sv
// rtl/rr_find_first.sv - first set bit of a request vector, searching upward from start with wrap-around
module rr_find_first
    import sram_arb_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(start) + k) % N);
            if (vec[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/sram_2p_arbiter.sv
// rtl/sram_2p_arbiter.sv - round-robin sharing of a dual-port SRAM among N_REQ requesters
module sram_2p_arbiter
    import sram_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_grant,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [N_REQ*DATA_W-1:0]   rsp_data,
    output logic [ADDR_W-1:0]         A0,
    output logic [ADDR_W-1:0]         A1,
    output logic [DATA_W-1:0]         D0,
    output logic [DATA_W-1:0]         D1,
    output logic [DATA_W-1:0]         WEM0,
    output logic [DATA_W-1:0]         WEM1,
    output logic                      WE0,
    output logic                      WE1,
    output logic                      CE0,
    output logic                      CE1,
    input  logic [DATA_W-1:0]         Q0,
    input  logic [DATA_W-1:0]         Q1,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int ID_W = clog2(N_REQ);

    logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
    logic [N_REQ-1:0][DATA_W-1:0] wdata_a;
    logic [N_REQ-1:0][DATA_W-1:0] rsp_a;

    logic [ID_W-1:0] rr_ptr, first_idx, second_idx, second_start, last_idx;
    logic [ID_W-1:0] pend_id0, pend_id1;
    logic            first_found, second_found, conflict, grant0, grant1;
    logic            pend_vld0, pend_vld1;
    logic [N_REQ-1:0] second_vec;

    assign addr_a   = req_addr;
    assign wdata_a  = req_wdata;
    assign rsp_data = rsp_a;

    rr_find_first #(.N(N_REQ), .IW(ID_W)) u_first (
        .vec   (req_valid),
        .start (rr_ptr),
        .found (first_found),
        .idx   (first_idx)
    );

    assign second_start = (int'(first_idx) == N_REQ - 1) ? '0 : first_idx + 1'b1;
    assign second_vec   = req_valid & ~(N_REQ'(1) << first_idx);

    rr_find_first #(.N(N_REQ), .IW(ID_W)) u_second (
        .vec   (second_vec),
        .start (second_start),
        .found (second_found),
        .idx   (second_idx)
    );

    // Same address with any write would race inside the macro, so port 1 backs off.
    assign conflict = first_found && second_found
                   && (addr_a[first_idx] == addr_a[second_idx])
                   && (req_we[first_idx] || req_we[second_idx]);

    assign grant0   = !RST && first_found;
    assign grant1   = !RST && second_found && !conflict;
    assign last_idx = grant1 ? second_idx : first_idx;

    always_comb begin
        req_grant = '0;
        if (grant0) req_grant[first_idx]  = 1'b1;
        if (grant1) req_grant[second_idx] = 1'b1;
    end

    always_comb begin
        CE0  = grant0;
        WE0  = grant0 && req_we[first_idx];
        A0   = grant0 ? addr_a[first_idx]  : '0;
        D0   = grant0 ? wdata_a[first_idx] : '0;
        WEM0 = {DATA_W{WE0}};
        CE1  = grant1;
        WE1  = grant1 && req_we[second_idx];
        A1   = grant1 ? addr_a[second_idx]  : '0;
        D1   = grant1 ? wdata_a[second_idx] : '0;
        WEM1 = {DATA_W{WE1}};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr       <= '0;
            pend_vld0    <= 1'b0;
            pend_vld1    <= 1'b0;
            pend_id0     <= '0;
            pend_id1     <= '0;
            conflict_cnt <= '0;
        end else begin
            if (grant0) rr_ptr <= (int'(last_idx) == N_REQ - 1) ? '0 : last_idx + 1'b1;
            pend_vld0 <= grant0 && !req_we[first_idx];
            pend_id0  <= first_idx;
            pend_vld1 <= grant1 && !req_we[second_idx];
            pend_id1  <= second_idx;
            if (conflict && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // Port owners are always distinct, so the two routes never collide.
    always_comb begin
        rsp_valid = '0;
        rsp_a     = '0;
        if (pend_vld0) begin
            rsp_valid[pend_id0] = 1'b1;
            rsp_a[pend_id0]     = Q0;
        end
        if (pend_vld1) begin
            rsp_valid[pend_id1] = 1'b1;
            rsp_a[pend_id1]     = Q1;
        end
    end

endmodule

// File: tb/tb_sram_2p_arbiter.sv
// tb/tb_sram_2p_arbiter.sv - directed scoreboard bench for sram_2p_arbiter with a behavioural 16x4 SRAM
module tb_sram_2p_arbiter;

    logic        CLK, RST;
    logic [3:0]  rv, rw;
    logic [15:0] ra, rd;
    logic [3:0]  req_grant, rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  A0, A1, D0, D1, WEM0, WEM1, Q0, Q1;
    logic        WE0, WE1, CE0, CE1;
    logic [15:0] conflict_cnt;

    sram_2p_arbiter dut (
        .CLK(CLK), .RST(RST),
        .req_valid(rv), .req_we(rw), .req_addr(ra), .req_wdata(rd),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WEM0(WEM0), .WEM1(WEM1),
        .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1), .Q0(Q0), .Q1(Q1),
        .conflict_cnt(conflict_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [3:0] init_val(input logic [3:0] a);
        if (a == 4'd5) return 4'hA;
        if (a == 4'd2) return 4'h7;
        return a ^ 4'h6;
    endfunction

    logic       mem_load;
    logic [3:0] mem [16];
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int a = 0; a < 16; a++) mem[a] <= init_val(4'(a));
        end else begin
            if (CE0 && WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
            if (CE1 && WE1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
        end
        if (CE0 && !WE0) Q0 <= mem[A0];
        if (CE1 && !WE1) Q1 <= mem[A1];
    end

    typedef struct {
        int         id;
        logic [3:0] data;
        int         due;
    } sb_t;
    sb_t        sb[$];
    logic [3:0] exp_mem [16];
    logic [3:0] g_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int mon_hit, mon_k;
    always @(negedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid[i] !== 1'b0) begin
                mon_hit = -1;
                for (int k = 0; k < sb.size(); k++)
                    if (mon_hit < 0 && sb[k].id == i) mon_hit = k;
                if (mon_hit < 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid[i]), 32'd0);
                end else begin
                    chk("rsp_data", 32'(rsp_data[i*4 +: 4]), 32'(sb[mon_hit].data));
                    chk("rsp_latency", 32'(cyc), 32'(sb[mon_hit].due));
                    sb.delete(mon_hit);
                end
            end
        end
        mon_k = 0;
        while (mon_k < sb.size()) begin
            if (sb[mon_k].due <= cyc) begin
                chk("rsp_missing", 32'(rsp_valid[sb[mon_k].id]), 32'd1);
                sb.delete(mon_k);
            end else begin
                mon_k++;
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic [3:0] a, input logic [3:0] d);
        rv[i]         = 1'b1;
        rw[i]         = we;
        ra[i*4 +: 4]  = a;
        rd[i*4 +: 4]  = d;
    endtask

    // Called one time unit after a rising edge; samples grants mid-cycle and records expectations.
    task automatic issue(input logic [3:0] exp_g, input string tag);
        logic [3:0] a;
        #3;
        g_last = req_grant;
        chk(tag, 32'(req_grant), 32'(exp_g));
        for (int i = 0; i < 4; i++) begin
            if (req_grant[i] === 1'b1 && !rw[i]) begin
                a = ra[i*4 +: 4];
                sb.push_back('{id: i, data: exp_mem[a], due: cyc + 1});
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req_grant[i] === 1'b1 && rw[i]) begin
                a = ra[i*4 +: 4];
                exp_mem[a] = rd[i*4 +: 4];
            end
        end
    endtask

    task automatic adv(input bit keep);
        @(posedge CLK);
        #1;
        if (!keep) rv = rv & ~g_last;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; mem_load = 1'b1;
        rv = 4'hF; rw = 4'h0; ra = 16'h3210; rd = 16'h0;
        g_last = 4'h0;
        for (int a = 0; a < 16; a++) exp_mem[a] = init_val(4'(a));
        #2;
        chk("rst_grant", 32'(req_grant), 32'd0);
        chk("rst_ce", 32'({CE0, CE1, WE0, WE1}), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rv = 4'h0; RST = 1'b0; mem_load = 1'b0;

        // Single read: requester 2, addr 5 holds 0xA
        set_req(2, 1'b0, 4'd5, 4'h0);
        issue(4'b0100, "single_grant");
        chk("single_ce0", 32'(CE0), 32'd1);
        chk("single_a0", 32'(A0), 32'd5);
        chk("single_we0", 32'(WE0), 32'd0);
        chk("single_ce1", 32'(CE1), 32'd0);
        chk("single_wem0", 32'(WEM0), 32'd0);
        adv(0);

        // Dual issue: write 3 to addr 1 on port 0, read addr 2 on port 1
        set_req(0, 1'b1, 4'd1, 4'h3);
        set_req(1, 1'b0, 4'd2, 4'h0);
        issue(4'b0011, "dual_grant");
        chk("dual_port0", 32'({CE0, WE0, A0, D0, WEM0}), 32'({1'b1, 1'b1, 4'd1, 4'h3, 4'hF}));
        chk("dual_port1", 32'({CE1, WE1, A1, WEM1}), 32'({1'b1, 1'b0, 4'd2, 4'h0}));
        adv(0);
        chk("dual_rr_ptr", 32'(dut.rr_ptr), 32'd2);

        set_req(3, 1'b0, 4'd9, 4'h0);
        issue(4'b1000, "filler_grant");
        adv(0);

        // Conflict: requester 0 writes 0xC to addr 4 while requester 3 reads addr 4
        set_req(0, 1'b1, 4'd4, 4'hC);
        set_req(3, 1'b0, 4'd4, 4'h0);
        issue(4'b0001, "conflict_grant");
        chk("conflict_port0", 32'({CE0, WE0, A0}), 32'({1'b1, 1'b1, 4'd4}));
        chk("conflict_ce1", 32'(CE1), 32'd0);
        adv(0);
        chk("conflict_cnt_1", 32'(conflict_cnt), 32'd1);
        issue(4'b1000, "deferred_grant");
        chk("deferred_port0", 32'({CE0, WE0, A0}), 32'({1'b1, 1'b0, 4'd4}));
        adv(0);

        // Fairness: all four read distinct addresses continuously
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'(10 + i), 4'h0);
        for (int c = 0; c < 6; c++) begin
            issue((c % 2 == 0) ? 4'b0011 : 4'b1100, "fair_grant");
            adv(1);
        end
        rv = 4'h0;
        adv(0);
        adv(0);
        chk("fair_conflict_cnt", 32'(conflict_cnt), 32'd1);

        // Reset mid-traffic with a read pending
        set_req(2, 1'b0, 4'd5, 4'h0);
        issue(4'b0100, "pre_reset_grant");
        adv(0);
        #1;
        RST = 1'b1;
        sb.delete();
        set_req(1, 1'b0, 4'd3, 4'h0);
        set_req(3, 1'b0, 4'd8, 4'h0);
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_grant", 32'(req_grant), 32'd0);
        chk("midrst_ce_we", 32'({CE0, CE1, WE0, WE1}), 32'd0);
        chk("midrst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        issue(4'b1010, "post_reset_grant");
        chk("post_reset_a0", 32'(A0), 32'd3);
        chk("post_reset_a1", 32'(A1), 32'd8);
        adv(0);
        adv(0);
        adv(0);

        // Saturation: two writers hammering the same address conflict every cycle
        set_req(0, 1'b1, 4'd6, 4'h1);
        set_req(1, 1'b1, 4'd6, 4'h2);
        repeat (65534) @(posedge CLK);
        #1;
        chk("sat_cnt_fffe", 32'(conflict_cnt), 32'hFFFE);
        @(posedge CLK);
        #1;
        chk("sat_cnt_ffff", 32'(conflict_cnt), 32'hFFFF);
        repeat (4) @(posedge CLK);
        #1;
        chk("sat_cnt_hold", 32'(conflict_cnt), 32'hFFFF);
        rv = 4'h0;
        adv(0);
        adv(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
